// File: rtl/regfile_sb.sv
// Register file with two write ports, two combinational read ports and a
// per-register pending (scoreboard) bit for tracking outstanding producers.
module regfile_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] rav,
  output logic [DATA_W-1:0] rbv,
  output logic              ra_busy,
  output logic              rb_busy,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] rw0,
  input  logic [DATA_W-1:0] val0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] rw1,
  input  logic [DATA_W-1:0] val1,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              rsv_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [ADDR_W:0]   r_cnt;
  logic              r_err;

  logic              w_we0;
  logic              w_we1;
  logic              w_rsvEn;
  logic [DEPTH-1:0]  w_pendClr;
  logic [DEPTH-1:0]  w_pendNext;
  logic              w_rsvErr;
  logic [ADDR_W:0]   w_popcnt;

  // Register 0 swallows writes and reservations when hardwired to zero.
  assign w_we0   = wr0 && !rst && !(ZERO_R0 != 0 && rw0 == '0);
  assign w_we1   = wr1 && !rst && !(ZERO_R0 != 0 && rw1 == '0);
  assign w_rsvEn = rsv && !rst && !(ZERO_R0 != 0 && rsv_addr == '0);

  // Writes clear pending first, so a same-edge reservation re-sets it and
  // only a register still pending after the clears counts as a double reserve.
  always_comb begin
    w_pendClr = r_pend;
    if (w_we0) w_pendClr[rw0] = 1'b0;
    if (w_we1) w_pendClr[rw1] = 1'b0;
    w_pendNext = w_pendClr;
    w_rsvErr   = 1'b0;
    if (w_rsvEn) begin
      w_pendNext[rsv_addr] = 1'b1;
      w_rsvErr             = w_pendClr[rsv_addr];
    end
    w_popcnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_popcnt = w_popcnt + {{ADDR_W{1'b0}}, w_pendNext[i]};
    end
  end

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_we0) r_mem[rw0] <= val0;
      if (w_we1) r_mem[rw1] <= val1;
      r_pend <= w_pendNext;
      r_cnt  <= w_popcnt;
      if (w_rsvErr) r_err <= 1'b1;
    end
  end

  always_comb begin
    rav = r_mem[ra];
    if (BYPASS != 0) begin
      if (w_we1 && rw1 == ra)      rav = val1;
      else if (w_we0 && rw0 == ra) rav = val0;
    end
    if (ZERO_R0 != 0 && ra == '0) rav = '0;
  end

  always_comb begin
    rbv = r_mem[rb];
    if (BYPASS != 0) begin
      if (w_we1 && rw1 == rb)      rbv = val1;
      else if (w_we0 && rw0 == rb) rbv = val0;
    end
    if (ZERO_R0 != 0 && rb == '0) rbv = '0;
  end

  assign ra_busy  = r_pend[ra];
  assign rb_busy  = r_pend[rb];
  assign pend_cnt = r_cnt;
  assign rsv_err  = r_err;

endmodule
